// File: rtl/xl_vcbuf_pkg.sv
// rtl/xl_vcbuf_pkg.sv - shared types, FSM encoding and sizing helper for the VC shared buffer
// Purpose: common typedefs sized for the default buffer geometry (4 VCs, 16 slots),
//          the INIT/WORK FSM encoding, the NULL pointer constant and the shared-pool
//          size calculation. No ports.
package xl_vcbuf_pkg;

  localparam int unsigned PKG_VCN   = 4;
  localparam int unsigned PKG_DEPTH = 16;
  localparam int unsigned VC_W      = $clog2(PKG_VCN);
  localparam int unsigned IDX_W     = $clog2(PKG_DEPTH);
  localparam int unsigned CNT_W     = $clog2(PKG_DEPTH + 1);

  typedef logic [VC_W-1:0]  vc_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Slot pointer; valid=0 means "no slot" (end of list / empty VC).
  typedef struct packed {
    logic valid;
    idx_t idx;
  } ptr_t;

  typedef enum logic {
    INIT = 1'b0,
    WORK = 1'b1
  } state_e;

  localparam ptr_t NULL_PTR = '{valid: 1'b0, idx: '0};

  // Slots left over for the shared pool once every VC's reservation is taken out.
  function automatic int unsigned shared_slots(int unsigned depth, int unsigned vcn,
                                               int unsigned rsv);
    return depth - vcn * rsv;
  endfunction

endpackage

// File: rtl/xl_free_list.sv
// rtl/xl_free_list.sv - circular FIFO of free slot indices
// Purpose: holds the indices of unused buffer slots. Push and pop may happen in the
//          same cycle; popping an empty list is never requested by the owner.
// Ports:
//   clk, rstn          clock, async active-low reset
//   push, push_idx     return a slot index to the list
//   pop                consume the index presented on pop_idx
//   pop_idx            oldest free index (valid while empty_n=1)
//   empty_n            list holds at least one index
module xl_free_list
  import xl_vcbuf_pkg::*;
#(
  parameter int unsigned DEPTH = PKG_DEPTH
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  idx_t push_idx,
  input  logic pop,
  output idx_t pop_idx,
  output logic empty_n
);

  idx_t slot_q [DEPTH];
  idx_t rd_q;
  idx_t wr_q;
  cnt_t count_q;

  assign pop_idx = slot_q[rd_q];
  assign empty_n = (count_q != '0);

  // DEPTH is a power of two, so pointer wrap is the natural overflow of idx_t.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + idx_t'(1);
      if (pop)  rd_q <= rd_q + idx_t'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) slot_q[wr_q] <= push_idx;
  end

endmodule

// File: rtl/xl_vc_shared_buffer.sv
// rtl/xl_vc_shared_buffer.sv - shared-memory linked-list multi-VC FIFO buffer
// Purpose: one slot array shared by VCN virtual channels, each VC a linked list of
//          slots. Each VC is guaranteed RSV slots; the rest form a shared pool.
//          Read data is first-word-fall-through for r_vc.
// Optional feature macro: XLVCB_HWM_EN adds per-VC high-water marks (hwm, hwm_clr).
// Ports:
//   clk, rstn        clock, async active-low reset
//   we, w_vc, d      write strobe, target VC, data
//   wr_rdy           per-VC write admission
//   re, r_vc         pop strobe, VC to read
//   q                head data of r_vc (0 when r_vc is empty)
//   empty_n          per-VC non-empty
//   cnt              per-VC occupancy, packed, VC0 at LSB
//   wr_drop          registered pulse after a write to a non-ready VC
//   hwm_clr, hwm     (XLVCB_HWM_EN) clear strobe and per-VC peak occupancy
module xl_vc_shared_buffer
  import xl_vcbuf_pkg::*;
#(
  parameter int unsigned VCN   = PKG_VCN,
  parameter int unsigned D     = 32,
  parameter int unsigned DEPTH = PKG_DEPTH,
  parameter int unsigned RSV   = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  vc_t                  w_vc,
  input  logic [D-1:0]         d,
  output logic [VCN-1:0]       wr_rdy,
  input  logic                 re,
  input  vc_t                  r_vc,
  output logic [D-1:0]         q,
  output logic [VCN-1:0]       empty_n,
  output logic [VCN*CNT_W-1:0] cnt,
  output logic                 wr_drop
`ifdef XLVCB_HWM_EN
  ,
  input  logic                 hwm_clr,
  output logic [VCN*CNT_W-1:0] hwm
`endif
);

  if (VCN * RSV >= DEPTH) begin : g_rsv_check
    $fatal(1, "xl_vc_shared_buffer: VCN*RSV must be less than DEPTH");
  end
  if (VCN != PKG_VCN || DEPTH != PKG_DEPTH) begin : g_pkg_check
    $fatal(1, "xl_vc_shared_buffer: VCN/DEPTH must match xl_vcbuf_pkg sizing");
  end

  localparam cnt_t SHARED   = cnt_t'(shared_slots(DEPTH, VCN, RSV));
  localparam cnt_t RSV_C    = cnt_t'(RSV);
  localparam cnt_t ONE      = cnt_t'(1);
  localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

  state_e       state_q;
  idx_t         init_idx_q;
  logic [D-1:0] mem_data_q [DEPTH];
  ptr_t         mem_next_q [DEPTH];
  ptr_t         head_q [VCN];
  ptr_t         tail_q [VCN];
  cnt_t         cnt_q  [VCN];
  cnt_t         cnt_d  [VCN];
  cnt_t         shared_used_q;
  cnt_t         shared_used_d;
  logic         wr_drop_q;

  logic fl_push;
  logic fl_pop;
  logic fl_empty_n;
  idx_t fl_push_idx;
  idx_t fl_pop_idx;

  logic work;
  logic wr_ok;
  logic rd_ok;
  logic same_vc;
  ptr_t new_ptr;

  assign work    = (state_q == WORK);
  assign wr_ok   = we & wr_rdy[w_vc];
  assign rd_ok   = work & re & empty_n[r_vc];
  assign same_vc = (w_vc == r_vc);
  assign new_ptr = '{valid: 1'b1, idx: fl_pop_idx};
  assign wr_drop = wr_drop_q;
  assign q       = head_q[r_vc].valid ? mem_data_q[head_q[r_vc].idx] : '0;

  always_comb begin
    for (int v = 0; v < VCN; v++) begin
      wr_rdy[v]             = work & fl_empty_n & ((cnt_q[v] < RSV_C) | (shared_used_q < SHARED));
      empty_n[v]            = (cnt_q[v] != '0);
      cnt[v*CNT_W +: CNT_W] = cnt_q[v];
      cnt_d[v]              = cnt_q[v] + cnt_t'(wr_ok && (w_vc == vc_t'(v)))
                                       - cnt_t'(rd_ok && (r_vc == vc_t'(v)));
    end
  end

  // Only occupancy above a VC's reservation draws on the shared pool. A same-VC
  // write+read leaves that VC's count unchanged, so the pool is untouched.
  always_comb begin
    shared_used_d = shared_used_q;
    if (!(wr_ok && rd_ok && same_vc)) begin
      if (wr_ok && (cnt_q[w_vc] >= RSV_C)) shared_used_d = shared_used_d + ONE;
      if (rd_ok && (cnt_q[r_vc] > RSV_C))  shared_used_d = shared_used_d - ONE;
    end
  end

  // During INIT the free list is seeded with every slot index, one per cycle.
  assign fl_push     = !work | rd_ok;
  assign fl_push_idx = work ? head_q[r_vc].idx : init_idx_q;
  assign fl_pop      = wr_ok;

  xl_free_list #(.DEPTH(DEPTH)) u_free_list (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fl_push),
    .push_idx (fl_push_idx),
    .pop      (fl_pop),
    .pop_idx  (fl_pop_idx),
    .empty_n  (fl_empty_n)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= INIT;
      init_idx_q    <= '0;
      shared_used_q <= '0;
      wr_drop_q     <= 1'b0;
      for (int v = 0; v < VCN; v++) begin
        head_q[v] <= NULL_PTR;
        tail_q[v] <= NULL_PTR;
        cnt_q[v]  <= '0;
      end
    end else begin
      wr_drop_q     <= work & we & ~wr_rdy[w_vc];
      shared_used_q <= shared_used_d;
      for (int v = 0; v < VCN; v++) cnt_q[v] <= cnt_d[v];
      if (state_q == INIT) begin
        init_idx_q <= init_idx_q + idx_t'(1);
        if (init_idx_q == LAST_IDX) state_q <= WORK;
      end
      if (rd_ok) begin
        head_q[r_vc] <= mem_next_q[head_q[r_vc].idx];
        if (cnt_q[r_vc] == ONE) tail_q[r_vc] <= NULL_PTR;
      end
      // Write updates come last so they win over a same-VC read of a single entry.
      if (wr_ok) begin
        tail_q[w_vc] <= new_ptr;
        if (cnt_q[w_vc] == '0 || (rd_ok && same_vc && cnt_q[w_vc] == ONE))
          head_q[w_vc] <= new_ptr;
      end
    end
  end

  // Slot storage is not reset: a slot is only read after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_data_q[fl_pop_idx] <= d;
      mem_next_q[fl_pop_idx] <= NULL_PTR;
      if (tail_q[w_vc].valid) mem_next_q[tail_q[w_vc].idx] <= new_ptr;
    end
  end

`ifdef XLVCB_HWM_EN
  cnt_t hwm_q [VCN];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int v = 0; v < VCN; v++) hwm_q[v] <= '0;
    end else begin
      for (int v = 0; v < VCN; v++) begin
        if (hwm_clr)                  hwm_q[v] <= '0;
        else if (cnt_d[v] > hwm_q[v]) hwm_q[v] <= cnt_d[v];
      end
    end
  end

  always_comb begin
    for (int v = 0; v < VCN; v++) hwm[v*CNT_W +: CNT_W] = hwm_q[v];
  end
`endif

endmodule

// File: tb/tb_xl_vc_shared_buffer.sv
// tb/tb_xl_vc_shared_buffer.sv - self-checking bench for xl_vc_shared_buffer
module tb_xl_vc_shared_buffer;

  localparam int VCN    = 4;
  localparam int D      = 8;
  localparam int DEPTH  = 16;
  localparam int RSV    = 2;
  localparam int SHARED = DEPTH - VCN * RSV;
  localparam int CW     = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [1:0]    w_vc = '0;
  logic [1:0]    r_vc = '0;
  logic [D-1:0]  d = '0;
  logic [3:0]    wr_rdy;
  logic [3:0]    empty_n;
  logic [D-1:0]  q;
  logic [19:0]   cnt;
  logic          wr_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xl_vc_shared_buffer #(.VCN(VCN), .D(D), .DEPTH(DEPTH), .RSV(RSV)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .we      (we),
    .w_vc    (w_vc),
    .d       (d),
    .wr_rdy  (wr_rdy),
    .re      (re),
    .r_vc    (r_vc),
    .q       (q),
    .empty_n (empty_n),
    .cnt     (cnt),
    .wr_drop (wr_drop)
  );

  // Reference model: one plain queue per VC plus an init countdown.
  logic [D-1:0] mq [VCN][$];
  int           init_left;
  logic         exp_drop;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_total();
    int t = 0;
    for (int v = 0; v < VCN; v++) t += mq[v].size();
    return t;
  endfunction

  function automatic int m_shared();
    int s = 0;
    for (int v = 0; v < VCN; v++) if (mq[v].size() > RSV) s += mq[v].size() - RSV;
    return s;
  endfunction

  function automatic bit m_rdy(int v);
    return (init_left == 0) && (m_total() < DEPTH) && (mq[v].size() < RSV || m_shared() < SHARED);
  endfunction

  task automatic m_reset();
    for (int v = 0; v < VCN; v++) mq[v].delete();
    init_left = DEPTH;
    exp_drop  = 1'b0;
  endtask

  task automatic m_step();
    bit rd;
    bit wr;
    if (!rstn) return;
    if (init_left > 0) begin
      init_left--;
      exp_drop = 1'b0;
      return;
    end
    rd       = re && (mq[r_vc].size() > 0);
    wr       = we && m_rdy(w_vc);
    exp_drop = we && !m_rdy(w_vc);
    if (rd) void'(mq[r_vc].pop_front());
    if (wr) mq[w_vc].push_back(d);
  endtask

  // Compare process: every negedge, all outputs against the model.
  logic [3:0]   e_rdy;
  logic [3:0]   e_ne;
  logic [19:0]  e_cnt;
  logic [D-1:0] e_q;
  always @(negedge clk) begin
    for (int v = 0; v < VCN; v++) begin
      e_rdy[v]         = m_rdy(v);
      e_ne[v]          = (mq[v].size() > 0);
      e_cnt[v*CW +: CW] = 5'(mq[v].size());
    end
    e_q = (mq[r_vc].size() > 0) ? mq[r_vc][0] : '0;
    chk("wr_rdy", 32'(wr_rdy), 32'(e_rdy));
    chk("empty_n", 32'(empty_n), 32'(e_ne));
    chk("cnt", 32'(cnt), 32'(e_cnt));
    chk("q", 32'(q), 32'(e_q));
    chk("wr_drop", 32'(wr_drop), 32'(exp_drop));
  end

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic wr(int v, int data);
    we = 1'b1; w_vc = 2'(v); d = 8'(data); re = 1'b0;
    step();
    we = 1'b0;
  endtask

  task automatic rd_expect(int v, int exp, string name);
    we = 1'b0; re = 1'b1; r_vc = 2'(v);
    #1;
    chk(name, 32'(q), 32'(exp));
    step();
    re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m_reset();
    // 1: reset state and INIT length
    #12;
    chk("rst_wr_rdy", 32'(wr_rdy), 32'h0);
    chk("rst_empty_n", 32'(empty_n), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_wr_drop", 32'(wr_drop), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    n = 0;
    while (wr_rdy !== 4'hF && n < 40) begin
      step();
      n++;
      if (n == 15) chk("init_rdy_15", 32'(wr_rdy), 32'h0);
    end
    chk("init_cycles", 32'(n), 32'd16);

    // 2: VC0 fills reservation plus shared pool, VC1 uses its reservation, overflow drops
    for (int i = 0; i < 10; i++) wr(0, i + 1);
    chk("vc0_cnt10", 32'(cnt[4:0]), 32'd10);
    chk("vc0_not_rdy", 32'(wr_rdy[0]), 32'd0);
    wr(1, 8'hA0);
    wr(1, 8'hA1);
    chk("vc1_cnt2", 32'(cnt[9:5]), 32'd2);
    wr(0, 8'h55);
    chk("drop_pulse", 32'(wr_drop), 32'd1);
    chk("drop_cnt0", 32'(cnt[4:0]), 32'd10);
    chk("rdy_full", 32'(wr_rdy), 32'b1100);
    for (int i = 0; i < 10; i++) rd_expect(0, i + 1, "vc0_drain");
    rd_expect(1, 8'hA0, "vc1_drain0");
    rd_expect(1, 8'hA1, "vc1_drain1");

    // 3: interleaved VCs keep their own order
    wr(1, 8'h11);
    wr(2, 8'h21);
    wr(1, 8'h12);
    rd_expect(1, 8'h11, "vc1_first");
    rd_expect(1, 8'h12, "vc1_second");
    rd_expect(2, 8'h21, "vc2_only");
    chk("empty_after_drain", 32'(empty_n), 32'h0);

    // 4: same-VC write+read on a single-entry VC
    wr(3, 8'h31);
    we = 1'b1; w_vc = 2'd3; d = 8'h32; re = 1'b1; r_vc = 2'd3;
    #1;
    chk("same_vc_q_old", 32'(q), 32'h31);
    step();
    we = 1'b0; re = 1'b0;
    #1;
    chk("same_vc_q_new", 32'(q), 32'h32);
    chk("same_vc_cnt3", 32'(cnt[19:15]), 32'd1);
    rd_expect(3, 8'h32, "vc3_drain");

    // 5: read of an empty VC is ignored
    rd_expect(2, 8'h00, "empty_read_q");
    chk("empty_read_cnt", 32'(cnt), 32'h0);
    wr(2, 8'h77);
    rd_expect(2, 8'h77, "after_empty_read");

    // Randomized traffic with varying write pressure
    for (int seg = 0; seg < 6; seg++) begin
      int pw = (seg % 2 == 0) ? 80 : 35;
      for (int c = 0; c < 500; c++) begin
        we   = ($urandom_range(0, 99) < pw);
        re   = ($urandom_range(0, 99) < 50);
        w_vc = 2'($urandom_range(0, 3));
        r_vc = 2'($urandom_range(0, 3));
        d    = 8'($urandom);
        step();
      end
    end
    we = 1'b0; re = 1'b0;

    // 6: reset mid-traffic with 12 words stored
    n = 0;
    while (m_total() != 12 && n < 60) begin
      we = 1'b0; re = 1'b0;
      if (m_total() > 12) begin
        for (int v = VCN - 1; v >= 0; v--) if (mq[v].size() > 0) begin re = 1'b1; r_vc = 2'(v); end
      end else begin
        for (int v = VCN - 1; v >= 0; v--) if (m_rdy(v)) begin we = 1'b1; w_vc = 2'(v); end
        d = 8'($urandom);
      end
      step();
      n++;
    end
    we = 1'b0; re = 1'b0;
    chk("pre_reset_total", 32'(cnt[4:0] + cnt[9:5] + cnt[14:10] + cnt[19:15]), 32'd12);
    rstn = 1'b0;
    m_reset();
    #1;
    chk("async_rdy", 32'(wr_rdy), 32'h0);
    chk("async_empty_n", 32'(empty_n), 32'h0);
    chk("async_cnt", 32'(cnt), 32'h0);
    chk("async_q", 32'(q), 32'h0);
    chk("async_drop", 32'(wr_drop), 32'h0);
    step();
    step();
    rstn = 1'b1;
    n = 0;
    while (wr_rdy !== 4'hF && n < 40) begin
      step();
      n++;
    end
    chk("reinit_cycles", 32'(n), 32'd16);
    for (int v = 0; v < VCN; v++) rd_expect(v, 8'h00, "post_reset_read");
    chk("post_reset_cnt", 32'(cnt), 32'h0);
    wr(1, 8'h5A);
    rd_expect(1, 8'h5A, "post_reset_write");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
